multisim_axi_sub_mem: RTL
=========================

MULTISIM_AXI_SUB_MEM -- requirements
Module: multisim_axi_sub_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data bus width; legal values 32, 64, 128.
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_WORDS, default 1024, memory depth in DATA_WIDTH words.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 AW: i_axi_s_awid ID_WIDTH, i_axi_s_awaddr ADDR_WIDTH, i_axi_s_awlen 8, i_axi_s_awvalid 1 (inputs); o_axi_s_awready 1 (output).
REQ-009 W: i_axi_s_wdata DATA_WIDTH, i_axi_s_wstrb DATA_WIDTH/8, i_axi_s_wlast 1, i_axi_s_wvalid 1 (inputs); o_axi_s_wready 1 (output).
REQ-010 B: o_axi_s_bid ID_WIDTH, o_axi_s_bresp 2, o_axi_s_bvalid 1 (outputs); i_axi_s_bready 1 (input).
REQ-011 AR: i_axi_s_arid ID_WIDTH, i_axi_s_araddr ADDR_WIDTH, i_axi_s_arlen 8, i_axi_s_arvalid 1 (inputs); o_axi_s_arready 1 (output).
REQ-012 R: o_axi_s_rid ID_WIDTH, o_axi_s_rdata DATA_WIDTH, o_axi_s_rresp 2, o_axi_s_rlast 1, o_axi_s_rvalid 1 (outputs); i_axi_s_rready 1 (input).

Function
REQ-013 SHALL act as an AXI subordinate responder with one outstanding transaction, using FSM states IDLE, WDATA, WRESP, RDATA.
REQ-014 In IDLE, awready and arready SHALL be driven combinationally from state, valids and grant pointer; all other readys and valids SHALL be 0.
REQ-015 Arbitration in IDLE: only awvalid -> write; only arvalid -> read; both -> the side not granted last; grant pointer updates on each AW or AR handshake.
REQ-016 AW handshake SHALL capture id, awaddr aligned down to DATA_WIDTH/8 bytes, and awlen; beat counter cleared; error flags cleared; next state WDATA.
REQ-017 In WDATA, wready SHALL be 1; each W handshake writes the bytes enabled by wstrb at the current word, increments the address by DATA_WIDTH/8 (INCR; burst type not decoded) and the beat counter.
REQ-018 A beat whose word index >= MEM_WORDS SHALL not write memory and SHALL set the decode-error flag.
REQ-019 wlast not matching (beat == awlen) SHALL set the slave-error flag; burst length is governed by awlen only.
REQ-020 W handshake on beat == awlen SHALL move to WRESP; bvalid SHALL rise the next cycle with bid = captured id.
REQ-021 bresp SHALL be 2'b11 if decode-error flag set, else 2'b10 if slave-error flag set, else 2'b00.
REQ-022 In WRESP, bvalid and bid/bresp SHALL be held stable until bready; the B handshake returns to IDLE.
REQ-023 AR handshake SHALL capture id, aligned address and arlen and enter RDATA; rvalid SHALL be 1 in the cycle after the AR handshake.
REQ-024 In RDATA, rdata SHALL be the word at the current address (0 with rresp 2'b11 if out of range, else rresp 2'b00); rlast = (beat == arlen); outputs held stable while rvalid and !rready.
REQ-025 Each R handshake SHALL advance address and beat; handshake with rlast returns to IDLE; the next AW/AR is accepted no earlier than the following cycle.
REQ-026 Word index SHALL be the address divided by DATA_WIDTH/8, compared unwrapped against MEM_WORDS; address increment SHALL be ADDR_WIDTH wide and wrap modulo 2^ADDR_WIDTH.
REQ-027 Memory contents SHALL initialise to zero at time 0 and SHALL NOT be affected by rst.

Reset
REQ-028 On rst assertion, regardless of the clock, the block SHALL enter IDLE with all valid and ready outputs 0, bresp/rresp 0, rlast 0, and grant pointer set so that write wins the first tie.
REQ-029 Reset asserted mid-burst SHALL abandon the transaction with no B or R response; memory writes already performed SHALL remain.
REQ-030 After rst deassertion, AW/AR SHALL be accepted on the first clock edge with a valid request.

Verification
REQ-031 AW id=3 addr=0x10 len=3, four W beats with wstrb all-ones and data 0xA0..0xA3 -> one B with bid=3, bresp=0 the cycle after the last W; AR addr=0x10 len=3 -> R data 0xA0..0xA3, rlast on the 4th beat only.
REQ-032 Simultaneous AW and AR from reset -> write accepted first; the next simultaneous pair -> read accepted first.
REQ-033 Write with wstrb=0x0F over 0xFFFF_FFFF_FFFF_FFFF, data 0 (DATA_WIDTH=64) -> readback 0xFFFF_FFFF_0000_0000.
REQ-034 Write burst len=1 starting at the last word -> second beat not stored, bresp=2'b11; read of the same range -> beat0 rresp 0, beat1 rdata 0, rresp 2'b11.
REQ-035 wlast asserted on beat 0 of len=2 burst -> three beats still accepted, bresp=2'b10; bready held low 5 cycles -> bvalid/bid/bresp stable throughout.
REQ-036 rst pulsed during beat 2 of a len=7 read -> rvalid 0 immediately; a new AR after reset is accepted and returns correct data.

Source files
------------

// File: rtl/multisim_axi_sub_mem.sv
// AXI subordinate backed by a zero-initialised word memory, one transaction in flight.
// Latency: B one cycle after the last W beat; first R beat one cycle after the AR handshake.
// Backpressure: B/R outputs hold until bready/rready; AW/AR are refused while a burst is active.
module multisim_axi_sub_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     i_axi_s_awid,
    input  logic [ADDR_WIDTH-1:0]   i_axi_s_awaddr,
    input  logic [7:0]              i_axi_s_awlen,
    input  logic                    i_axi_s_awvalid,
    output logic                    o_axi_s_awready,
    input  logic [DATA_WIDTH-1:0]   i_axi_s_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_axi_s_wstrb,
    input  logic                    i_axi_s_wlast,
    input  logic                    i_axi_s_wvalid,
    output logic                    o_axi_s_wready,
    output logic [ID_WIDTH-1:0]     o_axi_s_bid,
    output logic [1:0]              o_axi_s_bresp,
    output logic                    o_axi_s_bvalid,
    input  logic                    i_axi_s_bready,
    input  logic [ID_WIDTH-1:0]     i_axi_s_arid,
    input  logic [ADDR_WIDTH-1:0]   i_axi_s_araddr,
    input  logic [7:0]              i_axi_s_arlen,
    input  logic                    i_axi_s_arvalid,
    output logic                    o_axi_s_arready,
    output logic [ID_WIDTH-1:0]     o_axi_s_rid,
    output logic [DATA_WIDTH-1:0]   o_axi_s_rdata,
    output logic [1:0]              o_axi_s_rresp,
    output logic                    o_axi_s_rlast,
    output logic                    o_axi_s_rvalid,
    input  logic                    i_axi_s_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_W);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [7:0]            beat;
        logic                  dec_err;
        logic                  slv_err;
    } txn_t;

    state_t state_q, state_d;
    txn_t   txn_q, txn_d;
    logic   last_wr_q, last_wr_d;
    logic   mem_we;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range;
    logic                  beat_is_last;

    // Range check uses the full unwrapped index so addresses past the end never alias low words.
    assign word_idx     = txn_q.addr >> SHIFT;
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign in_range     = 64'(word_idx) < 64'(MEM_WORDS);
    assign beat_is_last = (txn_q.beat == txn_q.len);

    always_comb begin
        state_d         = state_q;
        txn_d           = txn_q;
        last_wr_d       = last_wr_q;
        mem_we          = 1'b0;
        o_axi_s_awready = 1'b0;
        o_axi_s_arready = 1'b0;
        o_axi_s_wready  = 1'b0;
        o_axi_s_bvalid  = 1'b0;
        o_axi_s_rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win the previous grant goes first.
                if (!rst) begin
                    o_axi_s_awready = i_axi_s_awvalid && (!i_axi_s_arvalid || !last_wr_q);
                    o_axi_s_arready = i_axi_s_arvalid && (!i_axi_s_awvalid || last_wr_q);
                end
                if (o_axi_s_awready) begin
                    txn_d.id      = i_axi_s_awid;
                    txn_d.addr    = i_axi_s_awaddr & ALIGN_MASK;
                    txn_d.len     = i_axi_s_awlen;
                    txn_d.beat    = 8'd0;
                    txn_d.dec_err = 1'b0;
                    txn_d.slv_err = 1'b0;
                    last_wr_d     = 1'b1;
                    state_d       = WDATA;
                end else if (o_axi_s_arready) begin
                    txn_d.id      = i_axi_s_arid;
                    txn_d.addr    = i_axi_s_araddr & ALIGN_MASK;
                    txn_d.len     = i_axi_s_arlen;
                    txn_d.beat    = 8'd0;
                    txn_d.dec_err = 1'b0;
                    txn_d.slv_err = 1'b0;
                    last_wr_d     = 1'b0;
                    state_d       = RDATA;
                end
            end
            WDATA: begin
                o_axi_s_wready = 1'b1;
                if (i_axi_s_wvalid) begin
                    mem_we = in_range;
                    if (!in_range) begin
                        txn_d.dec_err = 1'b1;
                    end
                    // Burst length follows awlen; a misplaced wlast is only reported.
                    if (i_axi_s_wlast != beat_is_last) begin
                        txn_d.slv_err = 1'b1;
                    end
                    txn_d.addr = txn_q.addr + ADDR_STEP;
                    txn_d.beat = txn_q.beat + 8'd1;
                    if (beat_is_last) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                o_axi_s_bvalid = 1'b1;
                if (i_axi_s_bready) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                o_axi_s_rvalid = 1'b1;
                if (i_axi_s_rready) begin
                    txn_d.addr = txn_q.addr + ADDR_STEP;
                    txn_d.beat = txn_q.beat + 8'd1;
                    if (beat_is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txn_q     <= '0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            txn_q     <= txn_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (mem_we && i_axi_s_wstrb[b]) begin
                mem[mem_idx][8*b +: 8] <= i_axi_s_wdata[8*b +: 8];
            end
        end
    end

    assign o_axi_s_bid   = txn_q.id;
    assign o_axi_s_bresp = (state_q != WRESP) ? 2'b00 :
                           txn_q.dec_err      ? 2'b11 :
                           txn_q.slv_err      ? 2'b10 : 2'b00;
    assign o_axi_s_rid   = txn_q.id;
    assign o_axi_s_rdata = (state_q == RDATA && in_range) ? mem[mem_idx] : '0;
    assign o_axi_s_rresp = (state_q == RDATA && !in_range) ? 2'b11 : 2'b00;
    assign o_axi_s_rlast = (state_q == RDATA) && beat_is_last;

endmodule
